// File: rtl/gost_coder_iter.sv
// Iterative Magma (GOST R 34.12-2015) block coder with AXI-Stream style handshakes.
// ROUNDS_PER_CYCLE rounds are unrolled per clock; one block in flight at a time.
module gost_coder_iter #(
  parameter int TDATA_WIDTH      = 64,
  parameter int KEY_WIDTH        = 256,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [KEY_WIDTH-1:0]   key_i,
  input  logic                   ss_tvalid_i,
  input  logic [TDATA_WIDTH-1:0] ss_tdata_i,
  input  logic                   ss_tuser_i,
  output logic                   ss_tready_o,
  output logic                   sm_tvalid_o,
  output logic [TDATA_WIDTH-1:0] sm_tdata_o,
  output logic                   sm_tuser_o,
  input  logic                   sm_tready_i
);

  // state | meaning
  // IDLE  | ready for a new block
  // RUN   | executing rounds, ROUNDS_PER_CYCLE per clock
  // DONE  | result presented, waiting for downstream

  localparam int N  = 32 / ROUNDS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  if (TDATA_WIDTH != 64) begin : g_bad_tdata
    $error("gost_coder_iter: TDATA_WIDTH must be 64");
  end
  if (KEY_WIDTH != 256) begin : g_bad_key
    $error("gost_coder_iter: KEY_WIDTH must be 256");
  end
  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
    $error("gost_coder_iter: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  // RFC 8891 pi0..pi7; entry v of each table sits at bits [4v+3:4v]
  localparam logic [7:0][63:0] PI = {
    64'h2BC96AF43850DE71,
    64'h73AD0B4FC19652E8,
    64'h0E34187BAC296FD5,
    64'hC24BE390D618A5F7,
    64'hB9E35A076F4D128C,
    64'h069C471EDAF2853B,
    64'hF0DB74E1C5A93286,
    64'h1F307D8E9B5A264C
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [31:0]       a_q, b_q, a_nx, b_nx;
  logic              user_q;
  logic [7:0][31:0]  kw;

  function automatic logic [31:0] sbox(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      y[4*i +: 4] = PI[i][{x[4*i +: 4], 2'b00} +: 4];
    end
    return y;
  endfunction

  function automatic logic [31:0] g_fn(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] s;
    s = sbox(a + k);
    return {s[20:0], s[31:21]};
  endfunction

  // Encrypt walks K1..K8 for rounds 0..23; decrypt only for rounds 0..7.
  // Elsewhere the order is reversed, i.e. index = ~r[2:0].
  function automatic logic [2:0] kidx(input logic [4:0] r, input logic dec);
    logic fwd;
    fwd = dec ? (r < 5'd8) : (r < 5'd24);
    return fwd ? r[2:0] : ~r[2:0];
  endfunction

  always_comb begin
    logic [31:0] a_t, b_t, tmp;
    logic [4:0]  rnd;
    a_t = a_q;
    b_t = b_q;
    tmp = '0;
    rnd = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      rnd = 5'(int'(cnt) * ROUNDS_PER_CYCLE + j);
      tmp = b_t ^ g_fn(a_t, kw[~kidx(rnd, user_q)]);
      b_t = a_t;
      a_t = tmp;
    end
    a_nx = a_t;
    b_nx = b_t;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ss_tvalid_i)                state_nx = RUN;
      RUN:     if (cnt == CW'(N - 1))          state_nx = DONE;
      DONE:    if (sm_tready_i)                state_nx = IDLE;
      default:                                 state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      user_q      <= 1'b0;
      kw          <= '0;
      ss_tready_o <= 1'b1;
      sm_tvalid_o <= 1'b0;
      sm_tdata_o  <= '0;
      sm_tuser_o  <= 1'b0;
    end else begin
      state       <= state_nx;
      ss_tready_o <= (state_nx == IDLE);
      sm_tvalid_o <= (state_nx == DONE);
      case (state)
        IDLE: if (ss_tvalid_i) begin
          a_q    <= ss_tdata_i[31:0];
          b_q    <= ss_tdata_i[63:32];
          user_q <= ss_tuser_i;
          kw     <= key_i;
          cnt    <= '0;
        end
        RUN: begin
          a_q <= a_nx;
          b_q <= b_nx;
          cnt <= cnt + 1'b1;
          // Last round has no swap: emit the swapped state halves.
          if (state_nx == DONE) begin
            sm_tdata_o <= {a_nx, b_nx};
            sm_tuser_o <= user_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gost_coder_iter.sv
// Directed bench for gost_coder_iter using the RFC 8891 Magma vector,
// covering latency, backpressure, reset abort, input isolation and throughput.
module tb_gost_coder_iter;

  localparam logic [255:0] KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  PT  = 64'hfedcba9876543210;
  localparam logic [63:0]  CT  = 64'h4ee901e5c2d8ca3d;

  logic         clk = 0;
  logic         rst = 1;
  logic [255:0] key = KEY;
  logic [63:0]  tdata = '0;
  logic         tuser = 0;
  logic         valid1 = 0, valid8 = 0;
  logic         sready1 = 0, sready8 = 0;
  logic         rdy1, rdy8, v1, v8, u1, u8;
  logic [63:0]  d1, d8;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  gost_coder_iter #(.ROUNDS_PER_CYCLE(1)) dut (
    .clk_i(clk), .rst_i(rst), .key_i(key),
    .ss_tvalid_i(valid1), .ss_tdata_i(tdata), .ss_tuser_i(tuser), .ss_tready_o(rdy1),
    .sm_tvalid_o(v1), .sm_tdata_o(d1), .sm_tuser_o(u1), .sm_tready_i(sready1)
  );

  gost_coder_iter #(.ROUNDS_PER_CYCLE(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .key_i(key),
    .ss_tvalid_i(valid8), .ss_tdata_i(tdata), .ss_tuser_i(tuser), .ss_tready_o(rdy8),
    .sm_tvalid_o(v8), .sm_tdata_o(d8), .sm_tuser_o(u8), .sm_tready_i(sready8)
  );

  // Drives one block into the selected DUT and waits until its result is valid.
  task automatic run_block(input logic use8, input logic [63:0] d, input logic u,
                           output int lat, output logic [63:0] q, output logic qu);
    tdata = d;
    tuser = u;
    if (use8) valid8 = 1; else valid1 = 1;
    @(posedge clk); #1;
    valid1 = 0;
    valid8 = 0;
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (use8 ? v8 : v1) begin
        lat = e;
        break;
      end
    end
    q  = use8 ? d8 : d1;
    qu = use8 ? u8 : u1;
  endtask

  task automatic drain1();
    sready1 = 1;
    @(posedge clk); #1;
    sready1 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy1 !== 1'b1) $display("FAIL reset_tready got %b exp 1", rdy1); else passed++;
    checks++; if (v1 !== 1'b0) $display("FAIL reset_tvalid got %b exp 0", v1); else passed++;
    checks++; if (d1 !== 64'h0) $display("FAIL reset_tdata got %h exp 0", d1); else passed++;
    checks++; if (u1 !== 1'b0) $display("FAIL reset_tuser got %b exp 0", u1); else passed++;
    checks++; if (rdy8 !== 1'b1) $display("FAIL reset_tready8 got %b exp 1", rdy8); else passed++;
    rst = 0;
  endtask

  task automatic test_encrypt();
    int lat; logic [63:0] q; logic qu;
    run_block(0, PT, 0, lat, q, qu);
    checks++; if (lat != 32) $display("FAIL enc_latency got %0d exp 32", lat); else passed++;
    checks++; if (q !== CT) $display("FAIL enc_data got %h exp %h", q, CT); else passed++;
    checks++; if (qu !== 1'b0) $display("FAIL enc_user got %b exp 0", qu); else passed++;
    checks++; if (rdy1 !== 1'b0) $display("FAIL enc_tready_done got %b exp 0", rdy1); else passed++;
    drain1();
    checks++; if (v1 !== 1'b0) $display("FAIL enc_tvalid_after got %b exp 0", v1); else passed++;
    checks++; if (rdy1 !== 1'b1) $display("FAIL enc_tready_after got %b exp 1", rdy1); else passed++;
  endtask

  task automatic test_decrypt();
    int lat; logic [63:0] q; logic qu;
    run_block(0, CT, 1, lat, q, qu);
    checks++; if (lat != 32) $display("FAIL dec_latency got %0d exp 32", lat); else passed++;
    checks++; if (q !== PT) $display("FAIL dec_data got %h exp %h", q, PT); else passed++;
    checks++; if (qu !== 1'b1) $display("FAIL dec_user got %b exp 1", qu); else passed++;
    drain1();
  endtask

  task automatic test_rpc8();
    int lat; logic [63:0] q; logic qu;
    run_block(1, PT, 0, lat, q, qu);
    checks++; if (lat != 4) $display("FAIL rpc8_latency got %0d exp 4", lat); else passed++;
    checks++; if (q !== CT) $display("FAIL rpc8_data got %h exp %h", q, CT); else passed++;
    sready8 = 1;
    @(posedge clk); #1;
    sready8 = 0;
    run_block(1, CT, 1, lat, q, qu);
    checks++; if (q !== PT) $display("FAIL rpc8_dec_data got %h exp %h", q, PT); else passed++;
    checks++; if (qu !== 1'b1) $display("FAIL rpc8_dec_user got %b exp 1", qu); else passed++;
    sready8 = 1;
    @(posedge clk); #1;
    sready8 = 0;
    checks++; if (v8 !== 1'b0) $display("FAIL rpc8_tvalid_after got %b exp 0", v8); else passed++;
  endtask

  task automatic test_backpressure();
    int lat; logic [63:0] q; logic qu;
    int bad;
    run_block(0, PT, 0, lat, q, qu);
    bad = 0;
    valid1 = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (d1 !== CT || v1 !== 1'b1 || rdy1 !== 1'b0) bad++;
    end
    valid1 = 0;
    checks++; if (bad != 0) $display("FAIL bp_hold got %0d bad cycles exp 0", bad); else passed++;
    drain1();
    checks++; if (v1 !== 1'b0) $display("FAIL bp_transfer got %b exp 0", v1); else passed++;
    checks++; if (rdy1 !== 1'b1) $display("FAIL bp_tready got %b exp 1", rdy1); else passed++;
  endtask

  task automatic test_reset_midflight();
    int lat; logic [63:0] q; logic qu;
    int seen;
    tdata = PT; tuser = 0; valid1 = 1;
    @(posedge clk); #1;
    valid1 = 0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1;
    sready1 = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++; if (rdy1 !== 1'b1) $display("FAIL rstmid_tready got %b exp 1", rdy1); else passed++;
    checks++; if (v1 !== 1'b0) $display("FAIL rstmid_tvalid got %b exp 0", v1); else passed++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (v1) seen++;
    end
    sready1 = 0;
    checks++; if (seen != 0) $display("FAIL rstmid_ghost got %0d exp 0", seen); else passed++;
    // Reset wins over an input handshake on the same edge.
    valid1 = 1; rst = 1;
    @(posedge clk); #1;
    rst = 0; valid1 = 0;
    @(posedge clk); #1;
    checks++; if (rdy1 !== 1'b1) $display("FAIL rst_priority got %b exp 1", rdy1); else passed++;
    run_block(0, PT, 0, lat, q, qu);
    checks++; if (q !== CT) $display("FAIL rstmid_next got %h exp %h", q, CT); else passed++;
    drain1();
  endtask

  task automatic test_key_change();
    int lat;
    tdata = PT; tuser = 0; valid1 = 1;
    @(posedge clk); #1;
    valid1 = 0;
    @(posedge clk); #1;
    key = '0; tdata = 64'h0123456789abcdef; tuser = 1;
    lat = -1;
    for (int e = 2; e <= 40; e++) begin
      @(posedge clk); #1;
      if (v1) begin lat = e; break; end
    end
    checks++; if (lat != 32) $display("FAIL keychg_latency got %0d exp 32", lat); else passed++;
    checks++; if (d1 !== CT) $display("FAIL keychg_data got %h exp %h", d1, CT); else passed++;
    checks++; if (u1 !== 1'b0) $display("FAIL keychg_user got %b exp 0", u1); else passed++;
    drain1();
    key = KEY;
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int good, results;
    tdata = PT; tuser = 0;
    valid1 = 1; sready1 = 1;
    good = 0; results = 0;
    for (int i = 0; i < 80; i++) begin
      if (rdy1 && valid1) acc.push_back(i);
      @(posedge clk); #1;
      if (v1) begin
        results++;
        if (d1 === CT) good++;
      end
    end
    valid1 = 0;
    repeat (40) @(posedge clk);
    #1;
    sready1 = 0;
    checks++; if (acc.size() < 3) $display("FAIL b2b_accepts got %0d exp 3", acc.size()); else passed++;
    checks++;
    if (acc.size() < 2 || acc[1] - acc[0] != 34)
      $display("FAIL b2b_period got %0d exp 34", acc.size() < 2 ? -1 : acc[1] - acc[0]);
    else passed++;
    checks++; if (results != 2 || good != 2) $display("FAIL b2b_results got %0d/%0d exp 2/2", good, results); else passed++;
    checks++; if (rdy1 !== 1'b1) $display("FAIL b2b_idle got %b exp 1", rdy1); else passed++;
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_rpc8();
    test_backpressure();
    test_reset_midflight();
    test_key_change();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gost_coder_iter.md
GOST_CODER_ITER -- requirements
Module: gost_coder_iter

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 64, block width; only 64 is legal, other values are an elaboration error.
REQ-002 SHALL have parameter KEY_WIDTH, default 256, key width; only 256 is legal.
REQ-003 SHALL have parameter ROUNDS_PER_CYCLE, default 1, rounds unrolled per clock; legal values 1, 2, 4, 8.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk_i  input  1  clock; all state changes on the rising edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 key_i  input  256  cipher key; K1=key_i[255:224] ... K8=key_i[31:0].
REQ-008 ss_tvalid_i  input  1  input block valid.
REQ-009 ss_tdata_i  input  64  input block; a=[31:0], b=[63:32].
REQ-010 ss_tuser_i  input  1  mode per block: 0 encrypt, 1 decrypt.
REQ-011 ss_tready_o  output  1  block can be accepted.
REQ-012 sm_tvalid_o  output  1  result valid.
REQ-013 sm_tdata_o  output  64  result block.
REQ-014 sm_tuser_o  output  1  mode the result was produced with.
REQ-015 sm_tready_i  input  1  downstream accepts result.

Function
REQ-016 SHALL implement Magma (GOST R 34.12-2015 / RFC 8891) with the RFC 8891 S-boxes pi0..pi7.
REQ-017 Round SHALL be: (a,b) <- (b XOR g(a,k), a); g(a,k) = ROTL11(S(a + k mod 2^32)); S applies pi_i to nibble i, nibble 0 = bits [3:0].
REQ-018 Encrypt key order SHALL be K1..K8 three times, then K8..K1; decrypt SHALL be K1..K8, then K8..K1 three times.
REQ-019 Last round SHALL omit the swap: result = {b XOR g(a,k32), a} placed as [63:32],[31:0].
REQ-020 FSM states SHALL be IDLE, RUN, DONE.
REQ-021 IDLE: ss_tready_o=1; ss_tvalid_i&&ss_tready_o on an edge latches tdata, tuser and key_i, clears round counter, goes to RUN.
REQ-022 RUN: ss_tready_o=0; each edge executes ROUNDS_PER_CYCLE rounds; after N=32/ROUNDS_PER_CYCLE edges goes to DONE.
REQ-023 Latency SHALL be exactly N clock edges from the accept edge to sm_tvalid_o=1 (32 for RPC=1, 4 for RPC=8).
REQ-024 DONE: sm_tvalid_o=1, sm_tdata_o and sm_tuser_o held stable; ss_tready_o=0 until the result transfers.
REQ-025 DONE with sm_tready_i=1 on an edge SHALL return to IDLE; sm_tvalid_o=0 on the following cycle.
REQ-026 Round counter SHALL be log2(N)+1 bits wide and not wrap within a block; no accept possible outside IDLE.
REQ-027 Changes on key_i, ss_tdata_i, ss_tuser_i after the accept edge SHALL NOT affect the block in flight.
REQ-028 sm_tready_i SHALL be ignored outside DONE; ss_tvalid_i SHALL be ignored outside IDLE.
REQ-029 Outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-030 Throughput SHALL be one block per N+2 cycles with sm_tready_i held high.

Reset
REQ-031 rst_i=1 on an edge SHALL force IDLE: ss_tready_o=1, sm_tvalid_o=0, sm_tdata_o=0, sm_tuser_o=0, round counter 0.
REQ-032 rst_i in RUN or DONE SHALL discard the in-flight block; no result for it is ever emitted.
REQ-033 rst_i SHALL take priority over a simultaneous input or output handshake.

Verification
REQ-034 RPC=1, key ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, tdata fedcba9876543210, tuser 0 -> sm_tdata_o 4ee901e5c2d8ca3d, sm_tuser_o 0, sm_tvalid_o 32 edges after accept.
REQ-035 Same key, tdata 4ee901e5c2d8ca3d, tuser 1 -> sm_tdata_o fedcba9876543210, sm_tuser_o 1.
REQ-036 RPC=8, REQ-034 vector -> same ciphertext, sm_tvalid_o 4 edges after accept.
REQ-037 sm_tready_i=0 for 10 cycles in DONE -> sm_tdata_o stable, ss_tready_o 0 throughout; transfer on first sm_tready_i=1.
REQ-038 rst_i pulsed after round 10 -> next cycle ss_tready_o=1, sm_tvalid_o=0; following REQ-034 block gives the correct result.
REQ-039 key_i set to 0 one cycle after accepting the REQ-034 block -> result still 4ee901e5c2d8ca3d.
